prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
Parametrised programmable timer. It is the successor to the fixed-constant count-to-N flag block. It adds a runtime terminal count, a clock prescaler, one-shot and periodic modes, start/stop control, a one-cycle tick and a sticky done flag. It serves as a general timebase and delay source for control FSMs in the design.

Parameters:
WIDTH, 8, width of main counter and terminal-count input
PRESC_W, 4, width of prescaler counter and prescale input

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; captures tc, prescale, periodic and (re)starts the timer
stop  input  1  pulse; aborts a running timer
periodic  input  1  sampled at start; 0 = one-shot, 1 = auto-reload
tc  input  WIDTH  terminal count, sampled at start
prescale  input  PRESC_W  count advances every prescale+1 clocks, sampled at start
clr_done  input  1  clears the sticky done flag
count  output  WIDTH  current count value
busy  output  1  high while in RUN
tick  output  1  one-cycle pulse per terminal event
done  output  1  sticky; set by a one-shot terminal event

Behaviour:
- Reset: clk, rst only (one clock domain). rst is synchronous and active-high, sampled on the rising edge of clk.
  - While rst is high: state=IDLE, count=0, busy=0, tick=0, done=0; internal tc_q, presc_q, presc_cnt and mode_q are all 0.
  - rst overrides every other input, including mid-run.
- States:
  - IDLE: count holds its last value.
  - RUN: counting.
  - DONE: one-shot finished; count holds tc_q.
- Start:
  - start=1 (stop=0) in any state: next cycle state=RUN, count=0, presc_cnt=0, busy=1, done=0.
  - tc, prescale and periodic are captured into tc_q, presc_q and mode_q.
  - start during RUN restarts with the new values; no tick is generated for the aborted run.
- Prescaler (RUN only):
  - presc_cnt increments each clock.
  - When presc_cnt==presc_q: presc_cnt returns to 0 and an advance enable is asserted for that cycle.
  - presc_q=0 gives an advance every clock.
- Counting:
  - On advance with count!=tc_q: count increments by 1.
  - On advance with count==tc_q: terminal event.
- Terminal event, registered (takes effect at the next edge):
  - tick=1 for exactly one cycle in both modes.
  - One-shot (mode_q=0): state=DONE, busy=0, done=1, count holds tc_q.
  - Periodic (mode_q=1): count=0, stays in RUN, busy stays 1, done unchanged.
- Timing:
  - Start sampled at edge t, with prescale=0: count=0 at t+1, count=k at t+1+k, tick high in cycle t+tc+2.
  - Periodic period = (tc+1)*(prescale+1) clocks.
- tc=0:
  - Terminal event on the first advance.
  - Periodic mode then ticks every prescale+1 clocks.
- Stop:
  - stop=1 in RUN: next cycle state=IDLE, busy=0, count frozen, presc_cnt=0, no tick, done unchanged.
  - stop in IDLE or DONE: no effect.
  - stop and start in the same cycle: stop wins.
- Terminal event coinciding with stop: stop wins; no tick, no done.
- clr_done:
  - Clears done next cycle.
  - If a terminal event sets done in the same cycle, set wins.
  - start also clears done.
- Arithmetic:
  - count never exceeds tc_q, so no wrap-around of the WIDTH counter occurs.
  - tc = 2^WIDTH-1 is legal.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Reset, then start with periodic=0, tc=10, prescale=0 -> count steps 0..10; tick and done rise 12 cycles after the start edge; busy falls with them; count holds 10.
2. Start with periodic=1, tc=3, prescale=1 -> tick every 8 clocks for at least 4 periods; count sequence 0,0,1,1,2,2,3,3,0...; done stays 0.
3. One-shot tc=20, stop at count=5 -> IDLE; count held at 5; busy=0; no tick or done. Assert start and stop together -> still no restart.
4. Start during RUN at count=7 with a new tc=2 -> count=0 next cycle; terminal event at 2; no tick for the aborted run.
5. Drive clr_done and the terminal event in the same cycle -> done=1. Then clr_done alone -> done=0 next cycle. A new start -> done=0.
6. Assert rst mid-run in periodic mode at count=2 -> all outputs 0 next cycle, IDLE. With tc=0 periodic, prescale=0 -> tick high every cycle after the first terminal event.

Source files
------------

// File: rtl/prog_timer.sv
// Programmable timer: a runtime terminal count, a clock prescaler, one-shot
// and periodic modes, and start/stop control. It drives a one-cycle tick on
// each terminal event and a sticky done flag when a one-shot run finishes.
// All outputs come straight from flops.
module prog_timer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [WIDTH-1:0]   tc,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               clr_done,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   tc_q;
    logic [PRESC_W-1:0] presc_q;
    logic               mode_q;
    logic [PRESC_W-1:0] presc_cnt;

    logic [WIDTH-1:0]   tc_nxt;
    logic [PRESC_W-1:0] presc_nxt;
    logic               mode_nxt;
    logic [PRESC_W-1:0] presc_cnt_nxt;
    logic [WIDTH-1:0]   count_nxt;
    logic               busy_nxt;
    logic               tick_nxt;
    logic               done_nxt;

    logic               running;
    logic               launch;
    logic               halt;
    logic               adv;
    logic               term;
    logic               term_ok;

    // Control decode. Stop beats start, and a restart hides a pending terminal event.
    assign running = (state == RUN);
    assign launch  = start & ~stop;
    assign halt    = stop & running;
    assign adv     = running & (presc_cnt == presc_q);
    assign term    = adv & (count == tc_q);
    assign term_ok = term & ~stop & ~start;

    // State register plus all datapath and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tc_q      <= {WIDTH{1'b0}};
            presc_q   <= {PRESC_W{1'b0}};
            mode_q    <= 1'b0;
            presc_cnt <= {PRESC_W{1'b0}};
            count     <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tc_q      <= tc_nxt;
            presc_q   <= presc_nxt;
            mode_q    <= mode_nxt;
            presc_cnt <= presc_cnt_nxt;
            count     <= count_nxt;
            busy      <= busy_nxt;
            tick      <= tick_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = state;
                end
            end
            RUN: begin
                if (launch) begin
                    state_nxt = RUN;
                end else if (halt) begin
                    state_nxt = IDLE;
                end else if (term_ok && !mode_q) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        tc_nxt        = tc_q;
        presc_nxt     = presc_q;
        mode_nxt      = mode_q;
        presc_cnt_nxt = presc_cnt;
        count_nxt     = count;
        tick_nxt      = 1'b0;
        busy_nxt      = (state_nxt == RUN);
        if (clr_done) begin
            done_nxt = 1'b0;
        end else begin
            done_nxt = done;
        end

        if (launch) begin
            tc_nxt        = tc;
            presc_nxt     = prescale;
            mode_nxt      = periodic;
            presc_cnt_nxt = {PRESC_W{1'b0}};
            count_nxt     = {WIDTH{1'b0}};
            done_nxt      = 1'b0;
        end else if (halt) begin
            // Count freezes where it is; prescaler is rearmed for a later start.
            presc_cnt_nxt = {PRESC_W{1'b0}};
        end else if (running) begin
            if (adv) begin
                presc_cnt_nxt = {PRESC_W{1'b0}};
                if (term) begin
                    tick_nxt = 1'b1;
                    if (mode_q) begin
                        count_nxt = {WIDTH{1'b0}};
                    end else begin
                        count_nxt = count;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                presc_cnt_nxt = presc_cnt + PRESC_W'(1);
            end
        end else begin
            presc_cnt_nxt = {PRESC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer (WIDTH=8, PRESC_W=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_prog_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] tc;
    logic [3:0] prescale;
    logic       clr_done;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    prog_timer #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .tc       (tc),
        .prescale (prescale),
        .clr_done (clr_done),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic p, input logic [7:0] t, input logic [3:0] ps);
        periodic = p;
        tc       = t;
        prescale = ps;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Directed scenarios.
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
        tc = 8'd0; prescale = 4'd0; clr_done = 1'b0;
        step();
        step();
        check_eq("rst_count", count, 32'd0);
        check_eq("rst_busy",  busy,  32'd0);
        check_eq("rst_tick",  tick,  32'd0);
        check_eq("rst_done",  done,  32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_busy", busy, 32'd0);

        // 1: one-shot tc=10, prescale=0
        launch(1'b0, 8'd10, 4'd0);
        check_eq("t1_count0", count, 32'd0);
        check_eq("t1_busy0",  busy,  32'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check_eq("t1_count", count, k);
            check_eq("t1_tick",  tick,  32'd0);
            check_eq("t1_busy",  busy,  32'd1);
        end
        step();
        check_eq("t1_tick_hi", tick,  32'd1);
        check_eq("t1_done_hi", done,  32'd1);
        check_eq("t1_busy_lo", busy,  32'd0);
        check_eq("t1_hold",    count, 32'd10);
        step();
        check_eq("t1_tick_lo", tick,  32'd0);
        check_eq("t1_done_st", done,  32'd1);
        check_eq("t1_hold2",   count, 32'd10);

        // 2: periodic tc=3, prescale=1 -> period 8
        launch(1'b1, 8'd3, 4'd1);
        check_eq("t2_done_clr", done,  32'd0);
        check_eq("t2_count0",   count, 32'd0);
        for (int j = 1; j <= 33; j++) begin
            step();
            check_eq("t2_count", count, (j / 2) % 4);
            check_eq("t2_tick",  tick,  ((j % 8) == 0) ? 32'd1 : 32'd0);
            check_eq("t2_done",  done,  32'd0);
        end
        check_eq("t2_busy", busy, 32'd1);

        // 3: stop at count 5, then start+stop together
        launch(1'b0, 8'd20, 4'd0);
        repeat (5) step();
        check_eq("t3_count5", count, 32'd5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("t3_busy",  busy,  32'd0);
        check_eq("t3_count", count, 32'd5);
        check_eq("t3_tick",  tick,  32'd0);
        check_eq("t3_done",  done,  32'd0);
        repeat (3) step();
        check_eq("t3_frozen", count, 32'd5);
        check_eq("t3_idle",   busy,  32'd0);
        start = 1'b1; stop = 1'b1; tc = 8'd20;
        step();
        start = 1'b0; stop = 1'b0;
        check_eq("t3_ss_busy",  busy,  32'd0);
        check_eq("t3_ss_count", count, 32'd5);
        step();
        check_eq("t3_ss_count2", count, 32'd5);
        check_eq("t3_ss_busy2",  busy,  32'd0);

        // stop coinciding with a terminal event
        launch(1'b0, 8'd2, 4'd0);
        step();
        step();
        check_eq("ts_count2", count, 32'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("ts_tick",  tick,  32'd0);
        check_eq("ts_done",  done,  32'd0);
        check_eq("ts_busy",  busy,  32'd0);
        check_eq("ts_count", count, 32'd2);
        step();
        check_eq("ts_tick2", tick, 32'd0);
        check_eq("ts_done2", done, 32'd0);

        // 4: restart at count 7 with tc=2
        launch(1'b0, 8'd20, 4'd0);
        repeat (7) step();
        check_eq("t4_count7", count, 32'd7);
        tc = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t4_count0", count, 32'd0);
        check_eq("t4_tick0",  tick,  32'd0);
        check_eq("t4_busy0",  busy,  32'd1);
        step();
        check_eq("t4_count1", count, 32'd1);
        check_eq("t4_tick1",  tick,  32'd0);
        step();
        check_eq("t4_count2", count, 32'd2);
        check_eq("t4_tick2",  tick,  32'd0);
        step();
        check_eq("t4_tick_hi", tick,  32'd1);
        check_eq("t4_done_hi", done,  32'd1);
        check_eq("t4_busy_lo", busy,  32'd0);
        check_eq("t4_hold",    count, 32'd2);

        // 5: clr_done against terminal event, clr_done alone, start clears
        launch(1'b0, 8'd1, 4'd0);
        check_eq("t5_start_clr", done, 32'd0);
        step();
        check_eq("t5_count1", count, 32'd1);
        clr_done = 1'b1;
        step();
        check_eq("t5_set_wins", done, 32'd1);
        check_eq("t5_tick",     tick, 32'd1);
        step();
        clr_done = 1'b0;
        check_eq("t5_cleared", done, 32'd0);
        check_eq("t5_tick_lo", tick, 32'd0);
        launch(1'b0, 8'd0, 4'd0);
        step();
        check_eq("t5_tc0_done", done,  32'd1);
        check_eq("t5_tc0_tick", tick,  32'd1);
        check_eq("t5_tc0_cnt",  count, 32'd0);
        launch(1'b0, 8'd0, 4'd0);
        check_eq("t5_restart_clr", done, 32'd0);
        check_eq("t5_restart_bsy", busy, 32'd1);
        step();

        // 6: reset mid-run (with start asserted), then tc=0 periodic
        launch(1'b1, 8'd5, 4'd0);
        step();
        step();
        check_eq("t6_count2", count, 32'd2);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check_eq("t6_rst_count", count, 32'd0);
        check_eq("t6_rst_busy",  busy,  32'd0);
        check_eq("t6_rst_tick",  tick,  32'd0);
        check_eq("t6_rst_done",  done,  32'd0);
        step();
        check_eq("t6_idle_busy",  busy,  32'd0);
        check_eq("t6_idle_count", count, 32'd0);
        launch(1'b1, 8'd0, 4'd0);
        check_eq("t6_tc0_tick0", tick, 32'd0);
        check_eq("t6_tc0_busy0", busy, 32'd1);
        for (int j = 0; j < 5; j++) begin
            step();
            check_eq("t6_tc0_tick",  tick,  32'd1);
            check_eq("t6_tc0_count", count, 32'd0);
            check_eq("t6_tc0_busy",  busy,  32'd1);
            check_eq("t6_tc0_done",  done,  32'd0);
        end

        // boundary: tc = 2^WIDTH-1 one-shot
        launch(1'b0, 8'hFF, 4'd0);
        for (int k = 1; k <= 255; k++) begin
            step();
            check_eq("tmax_count", count, k);
        end
        check_eq("tmax_no_tick", tick, 32'd0);
        step();
        check_eq("tmax_tick",  tick,  32'd1);
        check_eq("tmax_done",  done,  32'd1);
        check_eq("tmax_hold",  count, 32'd255);
        check_eq("tmax_busy",  busy,  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
